// File: rtl/echo_pkg.sv
// Shared types and constants for the echo/delay effect: sample type, FSM state
// encoding, captured-control record and the delay-step constant.
package echo_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int DELAY_SEL_W = 4;
  localparam int DEF_ADDR_W  = 12;

  // Delay grows in steps of 2^(ADDR_W - DELAY_SEL_W) samples per delay_sel code.
  localparam int DELAY_STEP  = 1 << (DEF_ADDR_W - DELAY_SEL_W);

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_MIX   = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  typedef struct packed {
    logic                   fx;
    logic [DELAY_SEL_W-1:0] sel;
    logic [1:0]             decay;
  } ctrl_t;

  function automatic int delay_step_shift(input int addr_w);
    return addr_w - DELAY_SEL_W;
  endfunction

endpackage

// File: rtl/echo_ram.sv
// Delay-line storage: simple dual-port RAM, one write port and one registered
// read port, depth 2^ADDR_W.
module echo_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: no reset on the array or read register; a reset port here would stop
  // the tools mapping it onto block RAM, and stale words are masked upstream.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/echo_delay.sv
// Echo/delay effect with feedback: IDLE -> READ -> MIX -> WRITE per sample.
// Define ECHO_SAT_EN to clamp the mix; otherwise it wraps in two's complement.
module echo_delay
  import echo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] audio_in,
  input  logic                     fx_enable,
  input  logic [DELAY_SEL_W-1:0]   delay_sel,
  input  logic [1:0]               decay_shift,
  output logic signed [DATA_W-1:0] audio_out,
  output logic                     out_valid,
  output logic                     drop_flag
);

  localparam int                STEP_SHIFT = delay_step_shift(ADDR_W);
  localparam logic [ADDR_W:0]   FILL_MAX   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   FILL_INC   = 1;
  localparam logic [ADDR_W-1:0] PTR_INC    = 1;

  state_t                     r_state;
  state_t                     w_state_nxt;
  ctrl_t                      r_ctrl;
  logic signed [DATA_W-1:0]   r_sample;
  logic signed [DATA_W-1:0]   r_result;
  logic signed [DATA_W-1:0]   r_audio_out;
  logic                       r_out_valid;
  logic                       r_drop_flag;
  logic [ADDR_W-1:0]          r_wr_ptr;
  logic [ADDR_W:0]            r_fill_cnt;

  logic                       w_accept;
  logic                       w_drop;
  logic                       w_ram_re;
  logic                       w_ram_we;
  logic [ADDR_W:0]            w_len;
  logic [ADDR_W-1:0]          w_rd_addr;
  logic signed [DATA_W-1:0]   w_rdata;
  logic signed [DATA_W-1:0]   w_delayed;
  logic [2:0]                 w_shift_amt;
  logic signed [DATA_W-1:0]   w_shifted;
  logic signed [DATA_W-1:0]   w_mix;
  logic signed [DATA_W-1:0]   w_result;

  assign w_accept = (r_state == ST_IDLE) && in_valid;
  assign w_drop   = (r_state != ST_IDLE) && in_valid;
  assign w_ram_re = (r_state == ST_READ);
  assign w_ram_we = (r_state == ST_WRITE);

  // Delay length and tap address come from the controls captured with the sample.
  assign w_len     = ((ADDR_W+1)'(r_ctrl.sel) + FILL_INC) << STEP_SHIFT;
  assign w_rd_addr = r_wr_ptr - w_len[ADDR_W-1:0];

  echo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (iCLK),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (r_result),
    .i_re    (w_ram_re),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata)
  );

  // Until L samples have been written the tap points at unwritten (stale) RAM.
  assign w_delayed   = (r_fill_cnt < w_len) ? '0 : w_rdata;
  assign w_shift_amt = {1'b0, r_ctrl.decay} + 3'd1;
  assign w_shifted   = w_delayed >>> w_shift_amt;

`ifdef ECHO_SAT_EN
  localparam logic signed [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W:0] w_sum;

  assign w_sum = {r_sample[DATA_W-1], r_sample} + {w_shifted[DATA_W-1], w_shifted};

  always_comb begin
    w_mix = w_sum[DATA_W-1:0];
    if (w_sum[DATA_W] != w_sum[DATA_W-1]) w_mix = w_sum[DATA_W] ? MIN_NEG : MAX_POS;
  end
`else
  // Low DATA_W bits of the widened sum are exactly the DATA_W-bit wrapped sum.
  assign w_mix = r_sample + w_shifted;
`endif

  assign w_result = r_ctrl.fx ? w_mix : r_sample;

  // NOTE: every output of a combinational block gets a default before the case,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (in_valid) w_state_nxt = ST_READ;
      ST_READ:  w_state_nxt = ST_MIX;
      ST_MIX:   w_state_nxt = ST_WRITE;
      ST_WRITE: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= ST_IDLE;
      r_ctrl      <= '0;
      r_sample    <= '0;
      r_result    <= '0;
      r_audio_out <= '0;
      r_out_valid <= 1'b0;
      r_drop_flag <= 1'b0;
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (r_state == ST_WRITE);

      if (w_accept) begin
        r_sample <= audio_in;
        r_ctrl   <= '{fx: fx_enable, sel: delay_sel, decay: decay_shift};
      end

      if (w_drop) r_drop_flag <= 1'b1;

      if (r_state == ST_MIX) r_result <= w_result;

      if (r_state == ST_WRITE) begin
        r_audio_out <= r_result;
        r_wr_ptr    <= r_wr_ptr + PTR_INC;
        if (r_fill_cnt != FILL_MAX) r_fill_cnt <= r_fill_cnt + FILL_INC;
      end
    end
  end

  assign audio_out = r_audio_out;
  assign out_valid = r_out_valid;
  assign drop_flag = r_drop_flag;

endmodule

// File: tb/tb_echo_delay.sv
// Self-checking bench for echo_delay: arithmetic table, impulse/ramp/wrap/drop/reset
// sequences and randomized samples against a history-based reference model.
module tb_echo_delay;
  import echo_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  sample_t    audio_in;
  logic       fx_enable;
  logic [3:0] delay_sel;
  logic [1:0] decay_shift;
  sample_t    audio_out;
  logic       out_valid;
  logic       drop_flag;

  int n_vec = 0;
  int n_err = 0;

  // Every value ever written to the delay line since the last reset, in order.
  sample_t hist[$];

  typedef struct {
    sample_t    prime;
    sample_t    x;
    logic [1:0] dec;
    sample_t    exp_sat;
    sample_t    exp_wrap;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  echo_delay #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .iCLK        (clk),
    .iRST_N      (rst_n),
    .in_valid    (in_valid),
    .audio_in    (audio_in),
    .fx_enable   (fx_enable),
    .delay_sel   (delay_sel),
    .decay_shift (decay_shift),
    .audio_out   (audio_out),
    .out_valid   (out_valid),
    .drop_flag   (drop_flag)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Output = input in bypass; otherwise input plus the attenuated value written
  // L samples ago (zero if fewer than L samples have been written).
  function automatic sample_t model_step(input sample_t x, input logic fx,
                                         input logic [3:0] sel, input logic [1:0] dec);
    int      n;
    int      len;
    int      delayed;
    int      mix;
    sample_t w;
    n       = hist.size();
    len     = (int'(sel) + 1) * 256;
    delayed = (n >= len) ? int'(hist[n-len]) : 0;
    if (!fx) begin
      w = x;
    end else begin
      mix = int'(x) + (delayed >>> (int'(dec) + 1));
`ifdef ECHO_SAT_EN
      if (mix > 32767)       w = 16'sh7FFF;
      else if (mix < -32768) w = 16'sh8000;
      else                   w = sample_t'(mix);
`else
      w = mix[15:0];
`endif
    end
    hist.push_back(w);
    return w;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic send(input sample_t x, input logic fx, input logic [3:0] sel,
                      input logic [1:0] dec, input string name, output sample_t got);
    sample_t exp;
    int      lat;
    exp         = model_step(x, fx, sel, dec);
    audio_in    = x;
    fx_enable   = fx;
    delay_sel   = sel;
    decay_shift = dec;
    in_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    audio_in    = ~x;
    fx_enable   = ~fx;
    delay_sel   = ~sel;
    decay_shift = ~dec;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check({name, " latency"}, lat, 3);
    check({name, " audio_out"}, audio_out, exp);
    got = audio_out;
    @(negedge clk);
    check({name, " strobe width"}, out_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("reset audio_out", audio_out, 16'h0000);
    check("reset out_valid", out_valid, 1'b0);
    check("reset drop_flag", drop_flag, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    sample_t got;
    sample_t x;
    sample_t exp;
    logic [1:0] dec;
    int cnt;

    tbl[0] = '{16'sh7000, 16'sh7000, 2'd0, 16'sh7FFF, 16'shA800};
    tbl[1] = '{16'sh4000, 16'sh1000, 2'd0, 16'sh3000, 16'sh3000};
    tbl[2] = '{16'sh8000, 16'sh8000, 2'd0, 16'sh8000, 16'sh4000};
    tbl[3] = '{16'shFFFF, 16'sh0005, 2'd3, 16'sh0004, 16'sh0004};
    tbl[4] = '{16'sh1234, 16'sh0000, 2'd1, 16'sh048D, 16'sh048D};
    tbl[5] = '{16'sh7FFF, 16'sh0001, 2'd3, 16'sh0800, 16'sh0800};
    tbl[6] = '{16'shC000, 16'sh0100, 2'd2, 16'shF900, 16'shF900};
    tbl[7] = '{16'sh7FFF, 16'sh7FFF, 2'd0, 16'sh7FFF, 16'shBFFE};

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    audio_in    = '0;
    fx_enable   = 1'b0;
    delay_sel   = '0;
    decay_shift = '0;
    @(negedge clk);
    do_reset();

    // Impulse through the shortest delay, no extra attenuation.
    for (int i = 0; i < 600; i++) begin
      x = (i == 0) ? 16'sh4000 : 16'sh0000;
      send(x, 1'b1, 4'd0, 2'd0, "impulse", got);
      if (i == 0)   check("impulse s0", got, 16'h4000);
      if (i == 256) check("impulse s256", got, 16'h2000);
      if (i == 512) check("impulse s512", got, 16'h1000);
    end

    // Bypass ramp.
    for (int i = 0; i < 1000; i++) begin
      send(sample_t'(i), 1'b0, 4'd0, 2'd0, "ramp", got);
      check("ramp passthru", got, i[15:0]);
    end

    // Arithmetic table: prime the line in bypass, then mix against it.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      x = (i < 8) ? tbl[i].prime : 16'sh0000;
      send(x, 1'b0, 4'd0, 2'd0, "prime", got);
    end
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].x, 1'b1, 4'd0, tbl[i].dec, "table", got);
`ifdef ECHO_SAT_EN
      exp = tbl[i].exp_sat;
`else
      exp = tbl[i].exp_wrap;
`endif
      check("table expected", got, exp);
    end

    // Second pulse two cycles after an accepted one must be dropped.
    check("drop_flag before", drop_flag, 1'b0);
    exp         = model_step(16'sh0111, 1'b1, 4'd0, 2'd0);
    audio_in    = 16'sh0111;
    fx_enable   = 1'b1;
    delay_sel   = 4'd0;
    decay_shift = 2'd0;
    in_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    audio_in = 16'sh7777;
    @(negedge clk);
    in_valid = 1'b0;
    check("drop_flag set", drop_flag, 1'b1);
    cnt = 0;
    got = '0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) begin
        cnt++;
        got = audio_out;
      end
      @(negedge clk);
    end
    check("drop out_valid count", cnt, 1);
    check("drop kept sample", got, exp);
    send(16'sh0222, 1'b1, 4'd1, 2'd1, "after drop", got);
    check("drop_flag sticky", drop_flag, 1'b1);

    // Longest delay: pointer wraps, echo of sample 0 lands on sample 4096.
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      if (i == 0)         x = 16'sh4000;
      else if (i == 4096) x = 16'sh0000;
      else                x = sample_t'(int'($urandom_range(0, 8191)) - 4096);
      dec = (i == 4096) ? 2'd0 : 2'($urandom_range(0, 3));
      send(x, 1'b1, 4'd15, dec, "long", got);
      if (i == 4095) check("long pre-fill", got, x);
      if (i == 4096) check("long echo s4096", got, 16'h2000);
    end

    // Reset while the sample sits in MIX.
    audio_in    = 16'sh0AAA;
    fx_enable   = 1'b1;
    delay_sel   = 4'd0;
    decay_shift = 2'd0;
    in_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort audio_out", audio_out, 16'h0000);
    check("abort drop_flag", drop_flag, 1'b0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 1) rst_n = 1'b1;
      if (out_valid) cnt++;
    end
    check("abort out_valid count", cnt, 0);
    check("abort audio_out after", audio_out, 16'h0000);
    hist.delete();
    send(16'sh0123, 1'b1, 4'd0, 2'd0, "post-reset", got);
    check("post-reset masked", got, 16'h0123);

    // Randomized samples with random gaps.
    for (int i = 0; i < 3000; i++) begin
      x = sample_t'($urandom_range(0, 65535));
      send(x, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), "random", got);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/echo_delay.md
ECHO_DELAY -- requirements
Module: echo_delay

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed sample width.
REQ-002 SHALL have parameter ADDR_W, default 12, delay-buffer address width (depth 2^ADDR_W samples).
REQ-003 SHALL have port iCLK  input  1  single clock for all logic (one clock; no other clock domains).
REQ-004 SHALL have port iRST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  one-cycle strobe, new sample on audio_in.
REQ-006 SHALL have port audio_in  input  DATA_W  signed sample from codec input path.
REQ-007 SHALL have port fx_enable  input  1  1 = echo applied, 0 = bypass.
REQ-008 SHALL have port delay_sel  input  4  delay length select.
REQ-009 SHALL have port decay_shift  input  2  feedback attenuation, delayed sample >>> (decay_shift+1).
REQ-010 SHALL have port audio_out  output  DATA_W  processed signed sample, held between strobes.
REQ-011 SHALL have port out_valid  output  1  one-cycle strobe, audio_out updated.
REQ-012 SHALL have port drop_flag  output  1  sticky: an in_valid arrived while busy.

Function
REQ-013 SHALL implement FSM IDLE -> READ -> MIX -> WRITE -> IDLE, one cycle per state.
REQ-014 SHALL accept in_valid only in IDLE; capture audio_in, fx_enable, delay_sel, decay_shift on that edge.
REQ-015 SHALL ignore in_valid in READ/MIX/WRITE and set drop_flag; sample discarded, FSM unaffected.
REQ-016 SHALL assert out_valid for exactly one cycle in WRITE, 3 cycles after the accepting edge; audio_out updates the same edge.
REQ-017 SHALL use delay length L = (delay_sel+1) * 2^(ADDR_W-4) samples (256..4096 at default).
REQ-018 SHALL read buffer address (wr_ptr - L) mod 2^ADDR_W in READ; RAM read latency 1 cycle, data used in MIX.
REQ-019 SHALL compute mix = audio_in + (delayed >>> (decay_shift+1)) in DATA_W+1 bits, arithmetic shift.
REQ-020 SHALL treat delayed as 0 while fill_cnt < L; fill_cnt counts written samples, saturates at 2^ADDR_W.
REQ-021 SHALL in bypass (captured fx_enable=0) output audio_in unchanged and write audio_in to buffer.
REQ-022 SHALL in echo mode write the mix result (feedback) at wr_ptr in WRITE, then wr_ptr <= wr_ptr+1, wrapping 2^ADDR_W-1 -> 0.
REQ-023 SHALL make delay_sel changes take effect at the next accepted sample only; fill_cnt is not cleared.

Reset
REQ-024 SHALL on iRST_N low immediately force: state IDLE, wr_ptr 0, fill_cnt 0, audio_out 0, out_valid 0, drop_flag 0.
REQ-025 SHALL abort any in-flight sample on reset mid-operation; no write or out_valid for it.
REQ-026 SHALL not require buffer RAM contents to be reset (masked by REQ-020).
REQ-027 SHALL clear drop_flag only by reset.

Configuration
REQ-028 SHALL use macro ECHO_SAT_EN: defined -> mix clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; undefined -> mix truncated to DATA_W bits (two's-complement wrap).

Structure
REQ-029 SHALL place sample_t, FSM state enum, and delay-step constant in package echo_pkg.
REQ-030 SHALL instantiate one sub-module echo_ram: simple dual-port, 1 write/1 registered read port, depth 2^ADDR_W.

Verification
REQ-031 SHALL cover: reset, fx_enable=1, delay_sel=0, decay_shift=0, impulse 0x4000 then zeros -> out 0x4000, sample 256 out 0x2000, sample 512 out 0x1000.
REQ-032 SHALL cover: fx_enable=0, ramp 0..999 -> audio_out equals audio_in each sample, out_valid 3 cycles after in_valid.
REQ-033 SHALL cover: in_valid=0x7000 with delayed 0x7000, decay_shift=0 -> 0x7FFF with ECHO_SAT_EN, 0xA800 without.
REQ-034 SHALL cover: in_valid pulses 2 cycles apart -> second dropped, drop_flag=1, one out_valid only.
REQ-035 SHALL cover: delay_sel=15 run 5000 samples -> wr_ptr wraps 4095->0, echo of sample 0 at sample 4096.
REQ-036 SHALL cover: iRST_N low during MIX -> no out_valid, audio_out=0, next sample after release sees delayed=0.
